// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB master port.
// Optional feature macro used by the top level: APB_TIMEOUT_EN.
package apb_master_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase watchdog: down-counter reloaded while clear is high, terminal-count compare.
// Instantiated only when APB_TIMEOUT_EN is defined.
module apb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of ACCESS cycles left after the current one.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= LOAD_VAL;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = enable && (cnt == '0);

endmodule

// File: rtl/apb_master_port.sv
// Single-outstanding APB3 master: valid/ready command in, SETUP/ACCESS transfer out, one response pulse.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES without pready.
//
// state  | meaning
// IDLE   | bus idle, cmd_ready high, command captured on cmd_valid
// SETUP  | psel=1, penable=0, one cycle
// ACCESS | psel=1, penable=1, waiting for pready (or timeout)
module apb_master_port #(
  parameter int ADDR_WIDTH     = apb_master_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = apb_master_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_slverr,
  output logic                  psel,
  output logic                  penable,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  import apb_master_pkg::*;

  state_t                state, state_nxt;
  logic                  psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic [DATA_WIDTH-1:0] pwdata_nxt;
  logic                  resp_valid_nxt, resp_slverr_nxt;
  logic [DATA_WIDTH-1:0] resp_rdata_nxt;
  logic                  timeout;

`ifdef APB_TIMEOUT_EN
  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != ACCESS),
    .enable (state == ACCESS),
    .expired(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout            = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_slverr <= 1'b0;
    end else begin
      state       <= state_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      paddr       <= paddr_nxt;
      pwrite      <= pwrite_nxt;
      pwdata      <= pwdata_nxt;
      resp_valid  <= resp_valid_nxt;
      resp_rdata  <= resp_rdata_nxt;
      resp_slverr <= resp_slverr_nxt;
    end
  end

  // Outputs are registered, so this block computes their values for the next cycle.
  always_comb begin
    state_nxt       = state;
    psel_nxt        = psel;
    penable_nxt     = penable;
    paddr_nxt       = paddr;
    pwrite_nxt      = pwrite;
    pwdata_nxt      = pwdata;
    resp_valid_nxt  = 1'b0;
    resp_rdata_nxt  = resp_rdata;
    resp_slverr_nxt = resp_slverr;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt  = SETUP;
          psel_nxt   = 1'b1;
          paddr_nxt  = cmd_addr;
          pwrite_nxt = cmd_write;
          pwdata_nxt = cmd_write ? cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        // A pready on the final allowed cycle completes normally rather than timing out.
        if (pready || timeout) begin
          state_nxt      = IDLE;
          psel_nxt       = 1'b0;
          penable_nxt    = 1'b0;
          paddr_nxt      = '0;
          pwrite_nxt     = 1'b0;
          pwdata_nxt     = '0;
          resp_valid_nxt = 1'b1;
          if (pready) begin
            resp_slverr_nxt = pslverr;
            resp_rdata_nxt  = pwrite ? '0 : prdata;
          end else begin
            resp_slverr_nxt = 1'b1;
            resp_rdata_nxt  = '0;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        paddr_nxt   = '0;
        pwrite_nxt  = 1'b0;
        pwdata_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_port.sv
// Directed self-checking bench for apb_master_port; covers the timeout path when APB_TIMEOUT_EN is defined.
module tb_apb_master_port;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_slverr;
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  int checks   = 0;
  int failures = 0;
  int n;

  apb_master_port #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_slverr(resp_slverr),
    .psel       (psel),
    .penable    (penable),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .pready     (pready),
    .prdata     (prdata),
    .pslverr    (pslverr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic s, input logic e);
    chk({tag, "_psel"}, 64'(psel), 64'(s));
    chk({tag, "_penable"}, 64'(penable), 64'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    #1;
    step(); step();
    rst = 1'b0;
    repeat (5) step();

    // reset state
    chk_bus("rst", 1'b0, 1'b0);
    chk("rst_paddr", 64'(paddr), 64'h0);
    chk("rst_pwrite", 64'(pwrite), 64'h0);
    chk("rst_pwdata", 64'(pwdata), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'h0);
    chk("rst_resp_slverr", 64'(resp_slverr), 64'h0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);

    // zero-wait write, slave ready throughout, prdata junk must not leak into write response
    pready = 1'b1; prdata = 32'hFFFF_FFFF;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0010; cmd_wdata = 32'hDEAD_BEEF;
    step();
    cmd_valid = 1'b0; cmd_wdata = 32'h0;
    chk_bus("wr_setup", 1'b1, 1'b0);
    chk("wr_setup_paddr", 64'(paddr), 64'h10);
    chk("wr_setup_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    chk("wr_setup_pwrite", 64'(pwrite), 64'h1);
    chk("wr_setup_cmd_ready", 64'(cmd_ready), 64'h0);
    step();
    chk_bus("wr_access", 1'b1, 1'b1);
    chk("wr_access_paddr", 64'(paddr), 64'h10);
    chk("wr_access_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
    chk("wr_access_pwrite", 64'(pwrite), 64'h1);
    chk("wr_access_resp_valid", 64'(resp_valid), 64'h0);
    step();
    chk("wr_resp_valid", 64'(resp_valid), 64'h1);
    chk("wr_resp_slverr", 64'(resp_slverr), 64'h0);
    chk("wr_resp_rdata", 64'(resp_rdata), 64'h0);
    chk_bus("wr_done", 1'b0, 1'b0);
    chk("wr_done_paddr", 64'(paddr), 64'h0);
    chk("wr_done_cmd_ready", 64'(cmd_ready), 64'h1);
    step();
    chk("wr_resp_pulse_end", 64'(resp_valid), 64'h0);

    // read with 4 wait cycles: response 7 cycles after accept
    pready = 1'b0; prdata = 32'h0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; cmd_wdata = 32'hAAAA_AAAA;
    step();
    cmd_valid = 1'b0;
    chk("rd_setup_pwdata", 64'(pwdata), 64'h0);
    chk("rd_setup_pwrite", 64'(pwrite), 64'h0);
    chk("rd_setup_paddr", 64'(paddr), 64'h20);
    for (int k = 1; k <= 5; k++) begin
      chk("rd_wait_resp_valid", 64'(resp_valid), 64'h0);
      step();
    end
    chk_bus("rd_last_access", 1'b1, 1'b1);
    chk("rd_last_access_paddr", 64'(paddr), 64'h20);
    pready = 1'b1; prdata = 32'h1234_5678;
    step();
    chk("rd_resp_valid", 64'(resp_valid), 64'h1);
    chk("rd_resp_rdata", 64'(resp_rdata), 64'h1234_5678);
    chk("rd_resp_slverr", 64'(resp_slverr), 64'h0);
    prdata = 32'h0BAD_0BAD;
    step();
    chk("rd_resp_pulse_end", 64'(resp_valid), 64'h0);
    chk("rd_rdata_held", 64'(resp_rdata), 64'h1234_5678);

    // back-to-back writes with cmd_valid held high
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h11;
    step();
    cmd_addr = 32'h40; cmd_wdata = 32'h22;
    chk("b2b_a_paddr", 64'(paddr), 64'h30);
    chk("b2b_a_pwdata", 64'(pwdata), 64'h11);
    step();
    chk_bus("b2b_a_access", 1'b1, 1'b1);
    step();
    chk("b2b_a_resp_valid", 64'(resp_valid), 64'h1);
    chk("b2b_gap_psel", 64'(psel), 64'h0);
    chk("b2b_gap_cmd_ready", 64'(cmd_ready), 64'h1);
    step();
    cmd_valid = 1'b0;
    chk_bus("b2b_b_setup", 1'b1, 1'b0);
    chk("b2b_b_paddr", 64'(paddr), 64'h40);
    chk("b2b_b_pwdata", 64'(pwdata), 64'h22);
    chk("b2b_b_resp_valid", 64'(resp_valid), 64'h0);
    step();
    step();
    chk("b2b_b_resp_valid_end", 64'(resp_valid), 64'h1);

    // read with slave error, then clean read
    step();
    pslverr = 1'b1; prdata = 32'hCAFE_0001;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    step();
    cmd_valid = 1'b0;
    step(); step();
    chk("err_resp_valid", 64'(resp_valid), 64'h1);
    chk("err_resp_slverr", 64'(resp_slverr), 64'h1);
    chk("err_resp_rdata", 64'(resp_rdata), 64'hCAFE_0001);
    pslverr = 1'b0; prdata = 32'h0000_0005;
    cmd_valid = 1'b1; cmd_addr = 32'h54;
    step();
    cmd_valid = 1'b0;
    pslverr = 1'b1;
    step();
    pslverr = 1'b0;
    step();
    chk("ok_resp_valid", 64'(resp_valid), 64'h1);
    chk("ok_resp_slverr", 64'(resp_slverr), 64'h0);
    chk("ok_resp_rdata", 64'(resp_rdata), 64'h5);

    // reset during ACCESS abandons the transfer
    step();
    pready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 32'h77;
    step();
    cmd_valid = 1'b0;
    step();
    chk_bus("rstx_access", 1'b1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_bus("rstx_after", 1'b0, 1'b0);
    chk("rstx_cmd_ready", 64'(cmd_ready), 64'h1);
    chk("rstx_resp_valid", 64'(resp_valid), 64'h0);
    pready = 1'b1;
    step();
    chk("rstx_no_resp", 64'(resp_valid), 64'h0);
    chk("rstx_idle_psel", 64'(psel), 64'h0);

    // pready on the 8th ACCESS cycle completes normally in either build
    pready = 1'b0; prdata = 32'h0000_00A5;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h70;
    step();
    cmd_valid = 1'b0;
    repeat (8) step();
    chk("last_cycle_penable", 64'(penable), 64'h1);
    chk("last_cycle_no_resp", 64'(resp_valid), 64'h0);
    pready = 1'b1;
    step();
    chk("last_cycle_resp_valid", 64'(resp_valid), 64'h1);
    chk("last_cycle_slverr", 64'(resp_slverr), 64'h0);
    chk("last_cycle_rdata", 64'(resp_rdata), 64'hA5);
    step();

    // slave never ready
    pready = 1'b0; prdata = 32'h0000_00FF;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80;
    step();
    cmd_valid = 1'b0;
    n = 1;
    while (resp_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
`ifdef APB_TIMEOUT_EN
    chk("to_latency", 64'(n), 64'd10);
    chk("to_resp_slverr", 64'(resp_slverr), 64'h1);
    chk("to_resp_rdata", 64'(resp_rdata), 64'h0);
    chk_bus("to_bus", 1'b0, 1'b0);
`else
    chk("nto_still_waiting", 64'(n), 64'd30);
    chk_bus("nto_bus", 1'b1, 1'b1);
    pready = 1'b1;
    step();
    chk("nto_resp_valid", 64'(resp_valid), 64'h1);
    chk("nto_resp_rdata", 64'(resp_rdata), 64'hFF);
`endif
    step();
    chk("final_resp_valid", 64'(resp_valid), 64'h0);
    chk("final_cmd_ready", 64'(cmd_ready), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_port.md
Name: apb_master_port

Overview:
- Single-outstanding APB3 master that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers.
- Returns one response pulse per completed transfer.
- Sits between on-chip control logic (register programming sequencer, test controller) and an APB slave bus.
- Drives exactly the master-side signal set: psel, penable, paddr, pwrite, pwdata out; pready, prdata, pslverr in.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr and paddr
DATA_WIDTH, 32, width of cmd_wdata, pwdata, prdata, resp_rdata
TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_wdata  input  DATA_WIDTH  write data; ignored for reads
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  DATA_WIDTH  read data; 0 for writes
resp_slverr  output  1  pslverr sampled at completion, or timeout
psel  output  1  APB select
penable  output  1  APB enable
paddr  output  ADDR_WIDTH  APB address
pwrite  output  1  APB direction
pwdata  output  DATA_WIDTH  APB write data
pready  input  1  slave ready
prdata  input  DATA_WIDTH  slave read data
pslverr  input  1  slave error

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All outputs are registered except cmd_ready, which equals (state==IDLE).
- Reset values, all 0: psel, penable, paddr, pwrite, pwdata, resp_valid, resp_rdata, resp_slverr. State resets to IDLE.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - psel=0, penable=0, paddr/pwrite/pwdata=0.
  - On cmd_valid: latch cmd_* into paddr/pwrite/pwdata (pwdata=0 for reads); next state SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0; next state ACCESS.
- ACCESS: psel=1, penable=1, paddr/pwrite/pwdata held stable.
  - Wait indefinitely while pready=0.
  - On a cycle with pready=1, at that edge:
    - state returns to IDLE; psel, penable, paddr, pwrite, pwdata return to 0.
    - resp_valid=1 for exactly one cycle.
    - resp_slverr=pslverr.
    - resp_rdata = prdata for reads, 0 for writes.
- Latency:
  - Command accept edge to psel=1: 1 cycle.
  - Zero-wait transfer: resp_valid asserts 3 cycles after the accept edge.
  - Each pready=0 ACCESS cycle adds 1.
- Throughput:
  - A new command is accepted in the cycle resp_valid is high; cmd_ready is high in that IDLE cycle.
  - Back-to-back issue rate: one transfer per 3 cycles.
- resp_rdata and resp_slverr hold their values until the next completion; resp_valid is the only qualifier.
- No response backpressure; the consumer must take resp_valid when it pulses.
- pready and pslverr are ignored outside ACCESS.
- Reset asserted mid-transfer:
  - Transfer is abandoned with no response.
  - psel/penable drop on the reset edge.
- cmd_* inputs may change freely except in the accept cycle.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCESS, cleared on entry.
  - If TIMEOUT_CYCLES consecutive ACCESS cycles pass with pready=0, the transfer aborts: return to IDLE, bus signals to 0, resp_valid=1, resp_slverr=1, resp_rdata=0.
  - A completion with pready=1 on the final allowed cycle wins over the timeout.
- Undefined: no counter; ACCESS waits forever; the TIMEOUT_CYCLES parameter has no effect.

Decomposition:
- Package apb_master_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, 2-bit);
  - default width constants ADDR_WIDTH=32, DATA_WIDTH=32.
- One natural sub-module, apb_timeout_counter: clear/enable/expired, present only under APB_TIMEOUT_EN.
- FSM and datapath live in the top level.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0; cmd_ready=1.
- Write addr=0x0000_0010, data=0xDEAD_BEEF, pready always 1:
  - psel=1 on the cycle after accept, penable=1 the next cycle;
  - paddr, pwdata and pwrite=1 stable in SETUP and ACCESS;
  - resp_valid pulses 3 cycles after accept with resp_slverr=0 and resp_rdata=0.
- Read addr=0x20, slave holds pready=0 for 4 ACCESS cycles, then pready=1 with prdata=0x1234_5678 -> resp_valid 7 cycles after accept, resp_rdata=0x1234_5678.
- Two back-to-back commands, cmd_valid held high -> second accepted in the resp_valid cycle of the first; psel low for exactly 1 cycle between transfers.
- Read with pslverr=1 at completion -> resp_slverr=1; next transfer with pslverr=0 -> resp_slverr=0.
- Reset asserted during ACCESS with pready=0 -> psel and penable 0 on the next edge, no resp_valid, state IDLE. With APB_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready never asserted -> resp_valid with resp_slverr=1 after 8 ACCESS cycles.
